mem_request_queue: RTL and testbench
====================================

MEM_REQUEST_QUEUE -- requirements
Module: mem_request_queue

Interface
REQ-001 Parameter DATA_WIDTH, 32: request data field width.
REQ-002 Parameter ADDR_WIDTH, 31: request address field width.
REQ-003 Parameter TID_WIDTH, 16: transaction ID width.
REQ-004 Parameter DEPTH_LOG2, 3: queue depth is 2**DEPTH_LOG2 entries (default 8).
REQ-005 Derived widths SHALL be REQ_WIDTH = 1+ADDR_WIDTH+DATA_WIDTH and DP_DATA_WIDTH = TID_WIDTH+REQ_WIDTH.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 req_valid  input  1  producer offers a request this cycle.
REQ-009 req_ready  output  1  queue can accept a request this cycle.
REQ-010 req_rw  input  1  access flag, stored unchanged.
REQ-011 req_address  input  ADDR_WIDTH  access address.
REQ-012 req_data  input  DATA_WIDTH  write data.
REQ-013 flush  input  1  synchronous discard of all queued entries.
REQ-014 rd_en  input  1  consumer pop request; driven by the memory controller's read control.
REQ-015 data_out  output  DP_DATA_WIDTH  head entry, packed {id, rw, address, data}, MSB first.
REQ-016 empty  output  1  no valid entry at head.
REQ-017 full  output  1  all 2**DEPTH_LOG2 entries occupied.
REQ-018 count  output  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2.

Function
REQ-019 Push SHALL occur on a rising edge where req_valid=1 and req_ready=1; req_ready SHALL equal !full, combinationally.
REQ-020 Pop SHALL occur on a rising edge where rd_en=1 and empty=0; rd_en with empty=1 SHALL be ignored, with no state change.
REQ-021 Output is first-word-fall-through: data_out SHALL present the head entry in the same cycle empty=0; data_out is don't-care while empty=1.
REQ-022 empty, full and count SHALL be decoded from registered state only, with no combinational path from req_valid or rd_en.
REQ-023 A pushed entry SHALL be {next_id, req_rw, req_address, req_data}, with next_id sampled at the push edge.
REQ-024 next_id SHALL increment by 1 per accepted push, modulo 2**TID_WIDTH (0xFFFF wraps to 0x0000); it SHALL NOT change otherwise.
REQ-025 Simultaneous push and pop with 0 < count < max: both SHALL occur, and count SHALL be unchanged.
REQ-026 Push with count=0: the entry SHALL become visible on data_out the following cycle, latency 1; a same-cycle rd_en SHALL be ignored.
REQ-027 With count=max, req_ready=0, so push is refused even if a pop occurs on the same edge; req_ready rises the cycle after the pop.
REQ-028 Read and write pointers SHALL wrap modulo 2**DEPTH_LOG2; entries SHALL be delivered in strict FIFO order across wrap.
REQ-029 flush=1 SHALL set count=0 and equalise the pointers on that edge, with priority over push and pop; a push offered that cycle is discarded and does not consume an ID.
REQ-030 flush SHALL NOT reset next_id.

Reset
REQ-031 With reset=0, regardless of clk: count=0, pointers=0, next_id=0, empty=1, full=0, req_ready=1, statistics counters=0.
REQ-032 Reset asserted mid-operation SHALL drop all entries; operation resumes on the first rising edge after reset=1.
REQ-033 Storage array contents need not be reset.

Configuration
REQ-034 Macro MEM_REQUEST_QUEUE_STATS_EN defined: adds outputs stat_accepted (32) and stat_stall (32).
REQ-035 stat_accepted counts accepted pushes; stat_stall counts cycles with req_valid=1 and req_ready=0; both saturate at 0xFFFFFFFF and are cleared only by reset.
REQ-036 Macro MEM_REQUEST_QUEUE_STATS_EN undefined: both ports and their counters are absent, and all other behaviour is identical.

Verification
REQ-037 Reset, then push rw=1, addr=0x10, data=7 -> next cycle empty=0, data_out={16'h0000,1,31'h10,32'h7}, count=1.
REQ-038 Push 8 requests with rd_en=0 -> full=1, req_ready=0; a 9th offer is refused, and the next pop returns ID 0.
REQ-039 Steady push+pop each cycle at count=3 for 20 cycles -> count stays 3; IDs emerge in order 0,1,2,... across pointer wrap.
REQ-040 Preset next_id to 0xFFFF via 65535 push/pop pairs, then push twice -> IDs 0xFFFF then 0x0000.
REQ-041 count=5, flush=1 with req_valid=1 -> count=0 and empty=1; the next accepted push carries the ID following the last accepted one.
REQ-042 With MEM_REQUEST_QUEUE_STATS_EN, hold req_valid=1 while full for 4 cycles -> stat_stall=4, and stat_accepted equals the number of pushes.

Source files
------------

// File: rtl/mem_request_queue.sv
// mem_request_queue
// -----------------
// First-word-fall-through request queue between a request producer and a
// memory controller. Every accepted request is tagged with a transaction ID
// that increments by one per accepted push, modulo 2**TID_WIDTH.
//
// Ports
//   clk           single clock; all state updates on its rising edge
//   reset         asynchronous, active-low reset
//   req_valid     producer offers a request this cycle
//   req_ready     queue can accept a request this cycle (equals !full)
//   req_rw        access flag, stored unchanged
//   req_address   access address
//   req_data      write data
//   flush         synchronous discard of every queued entry
//   rd_en         consumer pop request
//   data_out      head entry {id, rw, address, data}, valid while empty=0
//   empty         no entry at the head
//   full          all 2**DEPTH_LOG2 entries occupied
//   count         current occupancy, 0..2**DEPTH_LOG2
//   stat_accepted accepted pushes, saturating      (MEM_REQUEST_QUEUE_STATS_EN)
//   stat_stall    cycles with req_valid & !req_ready, saturating
//                                                  (MEM_REQUEST_QUEUE_STATS_EN)
//
// Optional feature: define MEM_REQUEST_QUEUE_STATS_EN to add the two
// statistics counters. Without it the ports and counters do not exist.
//
// Handshake: a request transfers on a rising edge where req_valid=1 and
// req_ready=1 and flush=0. req_ready depends only on registered state, so the
// producer may hold req_valid and its payload until it sees req_ready=1.
// A pop happens on a rising edge where rd_en=1, empty=0 and flush=0; rd_en
// while empty is ignored.

module mem_request_queue #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 31,
    parameter int TID_WIDTH     = 16,
    parameter int DEPTH_LOG2    = 3,
    localparam int REQ_WIDTH     = 1 + ADDR_WIDTH + DATA_WIDTH,
    localparam int DP_DATA_WIDTH = TID_WIDTH + REQ_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_rw,
    input  logic [ADDR_WIDTH-1:0]    req_address,
    input  logic [DATA_WIDTH-1:0]    req_data,
    input  logic                     flush,
    input  logic                     rd_en,
    output logic [DP_DATA_WIDTH-1:0] data_out,
    output logic                     empty,
    output logic                     full,
    output logic [DEPTH_LOG2:0]      count
`ifdef MEM_REQUEST_QUEUE_STATS_EN
    ,
    output logic [31:0]              stat_accepted,
    output logic [31:0]              stat_stall
`endif
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] MAX_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [TID_WIDTH-1:0]  TID_ONE = 1;

    logic [DP_DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0]    wr_ptr;
    logic [DEPTH_LOG2-1:0]    rd_ptr;
    logic [DEPTH_LOG2:0]      count_q;
    logic [TID_WIDTH-1:0]     next_id;

    logic push;
    logic pop;

    // Status is decoded from the occupancy register only.
    assign empty     = (count_q == '0);
    assign full      = (count_q == MAX_COUNT);
    assign count     = count_q;
    assign req_ready = !full;

    // flush wins over both push and pop; a push offered alongside flush is
    // discarded and does not consume an ID.
    assign push = req_valid && !full && !flush;
    assign pop  = rd_en && !empty && !flush;

    // Head entry falls through combinationally from the storage array.
    assign data_out = mem[rd_ptr];

    // Storage is not reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {next_id, req_rw, req_address, req_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            next_id <= '0;
        end else if (flush) begin
            // Equalise pointers by discarding everything between them.
            rd_ptr  <= wr_ptr;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + PTR_ONE;
                next_id <= next_id + TID_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef MEM_REQUEST_QUEUE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_accepted <= '0;
            stat_stall    <= '0;
        end else begin
            if (push && (stat_accepted != '1)) begin
                stat_accepted <= stat_accepted + 32'd1;
            end
            if (req_valid && !req_ready && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_request_queue.sv
// Testbench for mem_request_queue: directed scenarios plus a random phase,
// all compared against a queue-based reference model of the request queue.
module tb_mem_request_queue;

    localparam int DATA_WIDTH    = 32;
    localparam int ADDR_WIDTH    = 31;
    localparam int TID_WIDTH     = 16;
    localparam int DEPTH_LOG2    = 3;
    localparam int DEPTH         = 1 << DEPTH_LOG2;
    localparam int DPW           = TID_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH;

    logic                  clk;
    logic                  reset;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_rw;
    logic [ADDR_WIDTH-1:0] req_address;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  flush;
    logic                  rd_en;
    logic [DPW-1:0]        data_out;
    logic                  empty;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
`ifdef MEM_REQUEST_QUEUE_STATS_EN
    logic [31:0]           stat_accepted;
    logic [31:0]           stat_stall;
`endif

    mem_request_queue #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .TID_WIDTH  (TID_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rw      (req_rw),
        .req_address (req_address),
        .req_data    (req_data),
        .flush       (flush),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .empty       (empty),
        .full        (full),
        .count       (count)
`ifdef MEM_REQUEST_QUEUE_STATS_EN
        ,
        .stat_accepted (stat_accepted),
        .stat_stall    (stat_stall)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DPW-1:0]       exp_q[$];
    logic [TID_WIDTH-1:0] id_m;
    int unsigned          acc_m;
    int unsigned          stall_m;

    int n_cmp;
    int n_err;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int sz;
        sz = exp_q.size();
        check_eq("count", 128'(count), 128'(sz));
        check_eq("empty", 128'(empty), 128'(sz == 0));
        check_eq("full", 128'(full), 128'(sz == DEPTH));
        check_eq("req_ready", 128'(req_ready), 128'(sz != DEPTH));
        if (sz > 0) check_eq("data_out", 128'(data_out), 128'(exp_q[0]));
`ifdef MEM_REQUEST_QUEUE_STATS_EN
        check_eq("stat_accepted", 128'(stat_accepted), 128'(acc_m));
        check_eq("stat_stall", 128'(stat_stall), 128'(stall_m));
`endif
    endtask

    // One clock cycle: drive, check pre-edge outputs, advance model at the edge.
    task automatic step(input logic v, input logic rw, input logic [ADDR_WIDTH-1:0] a,
                        input logic [DATA_WIDTH-1:0] d, input logic rd, input logic fl);
        int sz;
        req_valid   = v;
        req_rw      = rw;
        req_address = a;
        req_data    = d;
        rd_en       = rd;
        flush       = fl;
        check_state();
        sz = exp_q.size();
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (rd && sz > 0) void'(exp_q.pop_front());
            if (v && sz < DEPTH) begin
                exp_q.push_back({id_m, rw, a, d});
                id_m = id_m + 1'b1;
                acc_m++;
            end
        end
        if (v && sz == DEPTH) stall_m++;
        #1;
    endtask

    task automatic rand_push(input logic rd);
        step(1'b1, 1'($urandom()), ADDR_WIDTH'($urandom()), DATA_WIDTH'($urandom()), rd, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        req_valid = 1'b0;
        rd_en     = 1'b0;
        flush     = 1'b0;
        #2;
        exp_q.delete();
        id_m    = '0;
        acc_m   = 0;
        stall_m = 0;
        check_state();
        @(posedge clk);
        #1;
        check_state();
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [TID_WIDTH-1:0] saved_id;

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        req_rw      = 1'b0;
        req_address = '0;
        req_data    = '0;
        apply_reset();

        // First push after reset, visible one cycle later with ID 0.
        step(1'b1, 1'b1, 31'h10, 32'h7, 1'b1, 1'b0);
        check_eq("first_entry", 128'(data_out), 128'({16'h0000, 1'b1, 31'h10, 32'h7}));
        check_eq("first_count", 128'(count), 128'd1);

        // Fill to full, then offer while full for 4 cycles.
        for (int i = 0; i < 7; i++) rand_push(1'b0);
        check_eq("full_flag", 128'(full), 128'd1);
        check_eq("full_ready", 128'(req_ready), 128'd0);
        for (int i = 0; i < 4; i++) rand_push(1'b0);
        check_eq("refused_count", 128'(count), 128'd8);
`ifdef MEM_REQUEST_QUEUE_STATS_EN
        check_eq("stall_four", 128'(stat_stall), 128'd4);
        check_eq("accepted_eight", 128'(stat_accepted), 128'd8);
`endif
        // Pop with a push offered at full: push refused, head is ID 0.
        check_eq("head_id0", 128'(data_out[DPW-1 -: TID_WIDTH]), 128'd0);
        rand_push(1'b1);
        check_eq("after_pop_ready", 128'(req_ready), 128'd1);
        check_eq("after_pop_count", 128'(count), 128'd7);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("drained", 128'(empty), 128'd1);

        // Steady push+pop at count 3 across pointer wrap.
        for (int i = 0; i < 3; i++) rand_push(1'b0);
        for (int i = 0; i < 20; i++) begin
            rand_push(1'b1);
            check_eq("steady_count", 128'(count), 128'd3);
        end

        // Flush at count 5 with a push offered.
        for (int i = 0; i < 2; i++) rand_push(1'b0);
        check_eq("pre_flush_count", 128'(count), 128'd5);
        saved_id = id_m;
        rand_push(1'b1);
        step(1'b1, 1'b0, 31'h5a5a, 32'hdead_beef, 1'b1, 1'b1);
        check_eq("flush_count", 128'(count), 128'd0);
        check_eq("flush_empty", 128'(empty), 128'd1);
        rand_push(1'b0);
        check_eq("post_flush_id", 128'(data_out[DPW-1 -: TID_WIDTH]), 128'(saved_id + 16'd1));

        // Walk next_id up to 0xFFFF with push/pop pairs at count 1.
        while (id_m != 16'hFFFF) rand_push(1'b1);
        rand_push(1'b1);
        check_eq("id_ffff", 128'(data_out[DPW-1 -: TID_WIDTH]), 128'h0ffff);
        rand_push(1'b1);
        check_eq("id_wrap", 128'(data_out[DPW-1 -: TID_WIDTH]), 128'h0);

        // Random traffic, including occasional flushes.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom()), ADDR_WIDTH'($urandom()),
                 DATA_WIDTH'($urandom()), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 40) == 0));
        end

        // Reset in the middle of traffic, then resume.
        for (int i = 0; i < 4; i++) rand_push(1'b0);
        #2;
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom()), ADDR_WIDTH'($urandom()),
                 DATA_WIDTH'($urandom()), 1'($urandom_range(0, 1)), 1'b0);
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
